ls_mem_ctrl: RTL
================

LS_MEM_CTRL -- requirements
Module: ls_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of dataAddr and mem_a.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the width of Sdata and Ldata; it is fixed at 32.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 The block SHALL have port dataEn, input, 1, request strobe from the load/store unit.
REQ-006 The block SHALL have port LSRW, input, 1, request direction: 0 = read, 1 = write.
REQ-007 The block SHALL have port dataAddr, input, ADDR_W, request byte address.
REQ-008 The block SHALL have port LSlen, input, 2, request byte count minus 1: 00 = 1 byte, 01 = 2, 10 = 3, 11 = 4.
REQ-009 The block SHALL have port Sdata, input, 32, store data, least-significant byte first.
REQ-010 The block SHALL have port LOutEn, output, 1, one-cycle completion pulse for both reads and writes.
REQ-011 The block SHALL have port Ldata, output, 32, assembled load data, zero-extended.
REQ-012 The block SHALL have port LSfree, output, 1, high when the block is idle and will accept a request.
REQ-013 The block SHALL have port mem_din, input, 8, RAM read byte, valid one cycle after its address is presented.
REQ-014 The block SHALL have port mem_dout, output, 8, RAM write byte.
REQ-015 The block SHALL have port mem_a, output, ADDR_W, RAM byte address.
REQ-016 The block SHALL have port mem_wr, output, 1, RAM write enable: 1 = write, 0 = read.

Function
REQ-017 The block SHALL implement the states IDLE, READ and WRITE; every output SHALL be registered.
REQ-018 In IDLE, when dataEn is sampled high at edge E0, the block SHALL:
- latch dataAddr, LSlen, LSRW and Sdata;
- set N = LSlen + 1 and byte counter k = 0;
- clear Ldata to 0, drive LSfree to 0;
- enter READ if LSRW = 0, or WRITE if LSRW = 1.
REQ-019 In READ, the block SHALL present byte address addr+k on mem_a after edge Ek (k = 0..N-1), with mem_wr = 0.
REQ-020 In READ, at edge Ek+1 the block SHALL capture mem_din into Ldata[8k+7:8k].
REQ-021 In WRITE, after edge Ek (k = 0..N-1), the block SHALL drive:
- mem_a = addr+k;
- mem_dout = Sdata[8k+7:8k];
- mem_wr = 1, for exactly one cycle per byte.
REQ-022 At edge EN the block SHALL:
- drive LOutEn = 1 for one cycle;
- drive LSfree = 1, mem_wr = 0, mem_a = 0;
- return to IDLE.
Latency from the dataEn sample to LOutEn high SHALL be N+1 cycles: 5 cycles for a word.
REQ-023 Ldata bytes at or above byte N SHALL read 0; Ldata SHALL hold its value until the next accepted request.
REQ-024 After a write, Ldata SHALL be 0.
REQ-025 Address arithmetic addr+k SHALL be modulo 2^ADDR_W, so 0xFFFFFFFF+1 wraps to 0; misaligned addresses SHALL be legal.
REQ-026 The block SHALL ignore dataEn while in READ or WRITE; a busy-time request SHALL be neither queued nor able to alter latched fields.
REQ-027 A dataEn high in the same cycle that LOutEn is high SHALL be accepted, since the block is IDLE in that cycle.
REQ-028 In IDLE with no request, the block SHALL drive mem_a = 0, mem_wr = 0, mem_dout = 0 and LOutEn = 0.

Reset
REQ-029 When rst is high at a clock edge, the block SHALL enter IDLE and set:
- LOutEn = 0, Ldata = 0, LSfree = 1;
- mem_a = 0, mem_dout = 0, mem_wr = 0;
- k = 0.
REQ-030 A reset during READ or WRITE SHALL abort the transfer with no LOutEn pulse; bytes already written SHALL remain in RAM.
REQ-031 The block SHALL accept a dataEn presented in the first cycle after rst deasserts.

Verification
REQ-032 The bench SHALL cover an LW read: RAM[0x100..0x103] = 0x11,0x22,0x33,0x44; dataEn, LSRW=0, LSlen=11, dataAddr=0x100 -> mem_a steps 0x100..0x103, and LOutEn pulses 5 cycles later with Ldata = 0x44332211.
REQ-033 The bench SHALL cover an LB read: RAM[0x7] = 0xF0; LSlen=00 -> LOutEn 2 cycles later with Ldata = 0x000000F0.
REQ-034 The bench SHALL cover an SH store: Sdata = 0xDEADBEEF, dataAddr = 0x20, LSlen=01 -> two mem_wr cycles writing 0xEF@0x20 and 0xBE@0x21, then LOutEn after 3 cycles with Ldata = 0.
REQ-035 The bench SHALL cover address wrap: LW at dataAddr = 0xFFFFFFFE -> mem_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-036 The bench SHALL cover a busy-time request: dataEn pulsed with dataAddr = 0x500 during an LW -> ignored, no second LOutEn, and the first result is intact.
REQ-037 The bench SHALL cover reset mid-write: rst asserted after byte 1 of an SW -> no LOutEn, LSfree = 1, mem_wr = 0 next cycle; a new LB then completes normally.

Source files
------------

// File: rtl/ls_mem_ctrl.sv
// ls_mem_ctrl: byte-serial load/store controller bridging a word-wide LSU port to a byte-wide RAM
module ls_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dataEn,
    input  logic              LSRW,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic [1:0]        LSlen,
    input  logic [DATA_W-1:0] Sdata,
    output logic              LOutEn,
    output logic [DATA_W-1:0] Ldata,
    output logic              LSfree,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_addr, w_addr, r_mem_a, w_mem_a;
    logic [1:0]        r_len, w_len, r_k, w_k, w_kn;
    logic [DATA_W-1:0] r_sdata, w_sdata, r_ldata, w_ldata;
    logic [7:0]        r_dout, w_dout;
    logic              r_outen, w_outen, r_free, w_free, r_wr, w_wr, w_last;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_sdata <= '0;
            r_k     <= '0;
            r_ldata <= '0;
            r_outen <= 1'b0;
            r_free  <= 1'b1;
            r_mem_a <= '0;
            r_dout  <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_len   <= w_len;
            r_sdata <= w_sdata;
            r_k     <= w_k;
            r_ldata <= w_ldata;
            r_outen <= w_outen;
            r_free  <= w_free;
            r_mem_a <= w_mem_a;
            r_dout  <= w_dout;
            r_wr    <= w_wr;
        end
    end
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_len   = r_len;
        w_sdata = r_sdata;
        w_k     = r_k;
        w_ldata = r_ldata;
        w_outen = 1'b0;
        w_free  = r_free;
        w_mem_a = r_mem_a;
        w_dout  = r_dout;
        w_wr    = 1'b0;
        w_kn    = r_k + 2'd1;
        w_last  = (r_k == r_len);
        case (r_state)
            IDLE: begin
                w_free  = 1'b1;
                w_mem_a = '0;
                w_dout  = '0;
                if (dataEn) begin
                    w_addr  = dataAddr;
                    w_len   = LSlen;
                    w_sdata = Sdata;
                    w_k     = '0;
                    w_ldata = '0;
                    w_free  = 1'b0;
                    w_mem_a = dataAddr;
                    w_wr    = LSRW;
                    w_dout  = LSRW ? Sdata[7:0] : 8'h00;
                    w_state = LSRW ? WRITE : READ;
                end
            end
            READ: begin
                // RAM data for the address presented this cycle lands in byte slot k
                w_ldata[{r_k, 3'b000} +: 8] = mem_din;
                if (w_last) begin
                    w_state = IDLE;
                    w_outen = 1'b1;
                    w_free  = 1'b1;
                    w_mem_a = '0;
                end else begin
                    w_k     = w_kn;
                    w_mem_a = r_addr + ADDR_W'(w_kn);
                end
            end
            WRITE: begin
                if (w_last) begin
                    w_state = IDLE;
                    w_outen = 1'b1;
                    w_free  = 1'b1;
                    w_mem_a = '0;
                    w_dout  = '0;
                end else begin
                    w_k     = w_kn;
                    w_mem_a = r_addr + ADDR_W'(w_kn);
                    w_dout  = r_sdata[{w_kn, 3'b000} +: 8];
                    w_wr    = 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
    end
    assign LOutEn   = r_outen;
    assign Ldata    = r_ldata;
    assign LSfree   = r_free;
    assign mem_a    = r_mem_a;
    assign mem_dout = r_dout;
    assign mem_wr   = r_wr;
endmodule
